count_uart_reporter: RTL and testbench
======================================

# count_uart_reporter

Downstream consumer of the 8-bit LED counter value on the MKRVIDOR4000 template. It watches the count, and whenever the value differs from the last one reported, it sends a snapshot over a TX-only UART (8N1, LSB first). The snapshot goes out as four ASCII bytes: high hex digit, low hex digit, CR, LF. Its output drives a header pin so the counter can be observed from a host terminal without looking at the LEDs.

## Interface

Parameters:
- CLK_HZ, default 48000000: wClk frequency in Hz.
- BAUD, default 115200: serial bit rate.
- CLKS_PER_BIT, default CLK_HZ/BAUD (integer truncation, 416 at defaults): clocks per bit. Values below 2 are illegal; elaboration must fail.

Ports:
- wClk  input  1  system clock; all logic on its rising edge.
- wRst  input  1  reset, synchronous, active-high.
- iCount  input  8  counter value from the upstream counter; synchronous to wClk.
- oTx  output  1  UART line; idle high.
- oBusy  output  1  high while a report is in progress.
- oReportDone  output  1  one-cycle pulse after the final stop bit of a report.

## Operation

- Registered state: rLastSent[7:0], rSnap[7:0], state, byte index (0..3), bit index (0..7), bit-period counter.
- Reset values: oTx=1, oBusy=0, oReportDone=0, rLastSent=8'h00, state IDLE, all counters 0.
- States:
  - IDLE: if iCount != rLastSent, load rSnap=iCount and rLastSent=iCount, set byte index 0, go to START. Otherwise stay.
  - START: oTx=0 for one bit period, then go to DATA.
  - DATA: drive the current byte LSB first, one bit period per bit, for 8 bits, then go to STOP.
  - STOP: oTx=1 for one bit period. If byte index < 3, increment it and go to START with no gap. If byte index = 3, go to IDLE.
- Byte sequence:
  - byte 0 = hex(rSnap[7:4])
  - byte 1 = hex(rSnap[3:0])
  - byte 2 = 8'h0D
  - byte 3 = 8'h0A
  - hex(n): n<=9 gives 8'h30+n; n>=10 gives 8'h41+(n-10) (uppercase).
- iCount changes while busy are ignored; no queue. On return to IDLE, the comparison uses the current iCount, so only the latest value is reported and intermediate values are dropped.
- iCount equal to rLastSent after reset (8'h00) produces no report.
- Reset mid-report aborts immediately. The partial frame is truncated; no completion is attempted.

## Timing

- Capture edge N, where IDLE sees a mismatch: oBusy=1 and oTx=0 from edge N+1.
- Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles. A byte is 10*CLKS_PER_BIT cycles; a report is 40*CLKS_PER_BIT cycles.
- oBusy is high for exactly 40*CLKS_PER_BIT cycles per report.
- Registered outputs, no combinational path from iCount to oTx.
- At the edge that ends the last stop bit: state goes to IDLE, oBusy=0, and oReportDone=1 for exactly one cycle.
- The IDLE comparison is active in that same cycle. Back-to-back reports are therefore separated by exactly one idle cycle with oTx=1.
- oReportDone never asserts for an aborted report.
- wRst wins over every other event. It is sampled at an edge, and at the following edge oTx=1, oBusy=0, oReportDone=0.

## Test plan

Bench uses CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10.

- **Power-on report:** wRst high 3 cycles, then iCount=8'hFF held. Required: exactly one report of bytes 46,46,0D,0A, 400 cycles of oBusy, one oReportDone pulse, then oTx stays 1 indefinitely.
- **No change:** iCount=8'h00 held after reset. Required: oTx=1 and oBusy=0 for 1000 cycles.
- **Digit encoding:** iCount set to 8'h3A, then after done to 8'h09. Required: bytes 33,41,0D,0A, then 30,39,0D,0A. The decoder checks every bit is 10 cycles wide and each stop bit is 1.
- **Change while busy:** iCount=8'h01; during byte 1, set 8'h02, then 8'h03. Required: report "01", exactly 1 idle cycle, then report "03". "02" is never sent.
- **Reset mid-report:** iCount=8'h55; assert wRst for 1 cycle in the middle of byte 1's data bits. Required: next edge oTx=1, oBusy=0, no oReportDone. Holding 8'h55 after release gives a fresh full report "55" starting on the cycle after release.
- **Simultaneous events:** iCount changes on the same edge oReportDone asserts. Required: the new value is captured on that cycle and its start bit begins at the next edge.

Source files
------------

// File: rtl/count_uart_reporter_if.sv
// Signal bundle between the LED counter and its UART reporter.
interface count_uart_reporter_if;
    logic [7:0] iCount;
    logic       oTx;
    logic       oBusy;
    logic       oReportDone;

    // Counter side: supplies the count, observes the serial line and status.
    modport master (
        output iCount,
        input  oTx,
        input  oBusy,
        input  oReportDone
    );

    // Reporter side.
    modport slave (
        input  iCount,
        output oTx,
        output oBusy,
        output oReportDone
    );
endinterface

// File: rtl/count_uart_reporter.sv
// Sends "HH\r\n" over an 8N1 TX-only UART whenever the counter value changes.
module count_uart_reporter #(
    parameter int unsigned CLK_HZ       = 48000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic                  wClk,
    input  logic                  wRst,
    count_uart_reporter_if.slave  bus
);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("count_uart_reporter: CLKS_PER_BIT must be at least 2");
    end

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [7:0]      last_q, last_d;
    logic [7:0]      snap_q, snap_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [7:0]      cur_byte;
    logic [2:0]      bit_idx_nxt;
    logic            bit_end;

    // Uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Select the byte of the report currently being shifted out.
    always_comb begin
        unique case (byte_idx_q)
            2'd0:    cur_byte = hex_ascii(snap_q[7:4]);
            2'd1:    cur_byte = hex_ascii(snap_q[3:0]);
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    assign bit_idx_nxt = bit_idx_q + 3'd1;
    assign bit_end     = (bit_cnt_q == CntMax);

    // Next-state logic; tx_d is the line level for the bit that starts at the next edge.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        snap_d     = snap_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (bus.iCount != last_q) begin
                    snap_d     = bus.iCount;
                    last_d     = bus.iCount;
                    byte_idx_d = 2'd0;
                    bit_idx_d  = 3'd0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte[0];
                    state_d   = StData;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_nxt;
                        tx_d      = cur_byte[bit_idx_nxt];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (byte_idx_q == 2'd3) begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_d       = 1'b0;
                        state_d    = StStart;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset aborts any report in flight without a done pulse.
    always_ff @(posedge wClk) begin
        if (wRst) begin
            state_q    <= StIdle;
            last_q     <= 8'h00;
            snap_q     <= 8'h00;
            byte_idx_q <= 2'd0;
            bit_idx_q  <= 3'd0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            snap_q     <= snap_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.oTx         = tx_q;
    assign bus.oBusy       = busy_q;
    assign bus.oReportDone = done_q;

endmodule

// File: tb/tb_count_uart_reporter.sv
// Randomized bench for count_uart_reporter against a position-based line model.
module tb_count_uart_reporter;

    localparam int Cpb    = 10;
    localparam int Report = 40 * Cpb;

    logic clk = 1'b0;
    logic rst = 1'b1;

    count_uart_reporter_if bus ();

    count_uart_reporter #(
        .CLK_HZ (1000),
        .BAUD   (100)
    ) dut (
        .wClk (clk),
        .wRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks   = 0;
    int n_errors   = 0;
    int done_seen  = 0;

    // Model: a report is a 400-cycle window; the line level follows from the position in it.
    int         m_rem  = 0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_snap = 8'h00;
    logic       m_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_of(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    function automatic logic exp_tx();
        int p, bit_n, byte_n, slot;
        logic [7:0] b;
        if (m_rem == 0) return 1'b1;
        p      = Report - m_rem;
        bit_n  = p / Cpb;
        byte_n = bit_n / 10;
        slot   = bit_n % 10;
        case (byte_n)
            0:       b = hex_of(int'(m_snap) / 16);
            1:       b = hex_of(int'(m_snap) % 16);
            2:       b = 8'h0D;
            default: b = 8'h0A;
        endcase
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    // One clock: advance the model on the same edge as the DUT, then compare.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_last = 8'h00;
            m_rem  = 0;
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            m_done = (m_rem == 0);
        end else begin
            m_done = 1'b0;
            if (bus.iCount != m_last) begin
                m_snap = bus.iCount;
                m_last = bus.iCount;
                m_rem  = Report;
            end
        end
        #1;
        check_eq("tx", {31'd0, bus.oTx}, {31'd0, exp_tx()});
        check_eq("busy", {31'd0, bus.oBusy}, {31'd0, m_rem > 0});
        check_eq("done", {31'd0, bus.oReportDone}, {31'd0, m_done});
        done_seen += int'(bus.oReportDone);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    // Step until the model reports idle; an exhausted budget counts as a failure.
    task automatic run_until_idle(input int budget);
        int left;
        left = budget;
        while (m_rem > 0 && left > 0) begin
            step();
            left--;
        end
        check_eq("idle_timeout", {31'd0, m_rem > 0}, 32'd0);
    endtask

    task automatic run_until_pos(input int p, input int budget);
        int left;
        left = budget;
        while (!(m_rem > 0 && Report - m_rem == p) && left > 0) begin
            step();
            left--;
        end
        check_eq("pos_timeout", {31'd0, left == 0}, 32'd0);
    endtask

    initial begin
        bus.iCount = 8'h00;

        // Power-on report of FF, then a long quiet line.
        do_reset(3);
        bus.iCount = 8'hFF;
        done_seen = 0;
        step();
        check_eq("por_start", {31'd0, bus.oTx}, 32'd0);
        run(1200);
        check_eq("por_done_cnt", done_seen, 32'd1);

        // Unchanged zero after reset produces nothing.
        bus.iCount = 8'h00;
        do_reset(3);
        done_seen = 0;
        run(1000);
        check_eq("nochg_done_cnt", done_seen, 32'd0);

        // Digit encoding: decimal and letter digits.
        bus.iCount = 8'h3A;
        step();
        run_until_idle(Report + 5);
        bus.iCount = 8'h09;
        step();
        run_until_idle(Report + 5);

        // Changes during a report: only the latest value follows, after one idle cycle.
        do_reset(2);
        bus.iCount = 8'h01;
        done_seen = 0;
        run_until_pos(12 * Cpb, Report);
        bus.iCount = 8'h02;
        run(3 * Cpb);
        bus.iCount = 8'h03;
        run_until_idle(Report);
        check_eq("chg_idle_gap", {31'd0, bus.oTx}, 32'd1);
        step();
        check_eq("chg_second_snap", {24'd0, m_snap}, 32'h03);
        check_eq("chg_second_start", {31'd0, bus.oTx}, 32'd0);
        run_until_idle(Report + 5);
        check_eq("chg_done_cnt", done_seen, 32'd2);

        // Reset in the middle of byte 1 data bits aborts; a fresh report follows.
        bus.iCount = 8'h55;
        done_seen = 0;
        run_until_pos(15 * Cpb, Report);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_done_cnt", done_seen, 32'd0);
        step();
        check_eq("abort_restart", {31'd0, bus.oBusy}, 32'd1);
        run_until_idle(Report + 5);
        check_eq("abort_fresh_done", done_seen, 32'd1);

        // New value presented in the done cycle starts on the very next edge.
        bus.iCount = 8'hC7;
        step();
        run_until_idle(Report + 5);
        bus.iCount = 8'h2E;
        step();
        check_eq("simul_start", {31'd0, bus.oTx}, 32'd0);
        run_until_idle(Report + 5);

        // Random values, hold times and occasional resets.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end
            bus.iCount = 8'($urandom);
            run(int'($urandom_range(0, 450)));
        end
        run_until_idle(Report + 5);
        run(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
